// File: rtl/fwd_scoreboard_if.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard_if
//   Bundles the D-stage issue info, the later-stage result buses and the
//   per-port read/forward signals of the forwarding scoreboard.
//
//   master : D-stage / datapath side (drives issue, results, raw GRF reads)
//   slave  : the scoreboard (returns forwarded operands and the stall)
//
//   Signals:
//     d_we, d_wa, d_tnew   issue info of the instruction in D
//     ext_freeze, flush    external stall / kill of the instruction leaving D
//     stage_data           result bus of slot k at [k*DW +: DW]
//     rd_addr, rd_tuse     per-port read address and Tuse
//     rd_data_in           per-port raw GRF data
//     rd_data_out          per-port forwarded operand
//     stall                internal D-stage stall (ext_freeze not included)
//     stall_cycles,
//     fwd_hits             statistics, present only with FWD_STAT_EN defined
// ---------------------------------------------------------------------------
interface fwd_scoreboard_if #(
    parameter int NREAD = 2,
    parameter int DEPTH = 3,
    parameter int AW    = 5,
    parameter int DW    = 32
) ();
    logic                  d_we;
    logic [AW-1:0]         d_wa;
    logic [1:0]            d_tnew;
    logic                  ext_freeze;
    logic                  flush;
    logic [DEPTH*DW-1:0]   stage_data;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*2-1:0]    rd_tuse;
    logic [NREAD*DW-1:0]   rd_data_in;
    logic [NREAD*DW-1:0]   rd_data_out;
    logic                  stall;
`ifdef FWD_STAT_EN
    logic [31:0]           stall_cycles;
    logic [31:0]           fwd_hits;
`endif

    modport master (
        output d_we, d_wa, d_tnew, ext_freeze, flush, stage_data,
               rd_addr, rd_tuse, rd_data_in,
        input  rd_data_out, stall
`ifdef FWD_STAT_EN
        , input stall_cycles, fwd_hits
`endif
    );

    modport slave (
        input  d_we, d_wa, d_tnew, ext_freeze, flush, stage_data,
               rd_addr, rd_tuse, rd_data_in,
        output rd_data_out, stall
`ifdef FWD_STAT_EN
        , output stall_cycles, fwd_hits
`endif
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
//   Register-dependency scoreboard for the 5-stage pipeline. Tracks pending
//   GRF writes in a shift register of per-stage slots (slot 0 = E,
//   slot DEPTH-1 = W). For every read port it forwards the youngest ready
//   result and raises a D-stage stall when a needed result cannot be ready
//   by that port's Tuse.
//
//   Ports:
//     clk    pipeline clock, rising edge
//     reset  asynchronous, active-low; clears all slots
//     bus    fwd_scoreboard_if.slave (issue, result buses, read ports)
//
//   Optional feature: define FWD_STAT_EN to add the stall_cycles and
//   fwd_hits statistics counters (wrap at 2^32, cleared by reset).
// ---------------------------------------------------------------------------
module fwd_scoreboard #(
    parameter int NREAD = 2,
    parameter int DEPTH = 3,   // legal 2..4
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    fwd_scoreboard_if.slave   bus
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] wa;
        logic [1:0]    tnew;
    } slot_t;

    slot_t slot_q [DEPTH];
    slot_t slot_d [DEPTH];

    logic [NREAD*DW-1:0] fwd_data;
    logic                stall_int;
    logic                issue_ok;

    // Per-port scratch for the priority search
    logic                found;
    logic [1:0]          win_tnew;
    logic [DW-1:0]       win_data;
    logic [AW-1:0]       addr;
    logic [1:0]          tuse;
`ifdef FWD_STAT_EN
    logic [31:0]         hit_cnt;
`endif

    // -----------------------------------------------------------------------
    // Forwarding select and hazard detection
    // -----------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        fwd_data  = '0;
        stall_int = 1'b0;
        found     = 1'b0;
        win_tnew  = '0;
        win_data  = '0;
        addr      = '0;
        tuse      = '0;
`ifdef FWD_STAT_EN
        hit_cnt   = '0;
`endif
        for (int p = 0; p < NREAD; p++) begin
            addr     = bus.rd_addr[p*AW +: AW];
            tuse     = bus.rd_tuse[p*2 +: 2];
            found    = 1'b0;
            win_tnew = '0;
            win_data = '0;
            // Walk oldest to youngest so the youngest match overwrites.
            for (int k = DEPTH-1; k >= 0; k--) begin
                if (slot_q[k].valid && slot_q[k].wa != '0 && slot_q[k].wa == addr) begin
                    found    = 1'b1;
                    win_tnew = slot_q[k].tnew;
                    win_data = bus.stage_data[k*DW +: DW];
                end
            end
            if (found && win_tnew == 2'd0) begin
                fwd_data[p*DW +: DW] = win_data;
`ifdef FWD_STAT_EN
                hit_cnt = hit_cnt + 32'd1;
`endif
            end else begin
                fwd_data[p*DW +: DW] = bus.rd_data_in[p*DW +: DW];
            end
            // An older match hidden behind a younger one never stalls.
            if (found && win_tnew > tuse)
                stall_int = 1'b1;
        end
    end

    assign bus.rd_data_out = fwd_data;
    assign bus.stall       = stall_int;

    // -----------------------------------------------------------------------
    // Slot next state: E takes the D issue or a bubble, later slots always
    // advance with a saturating Tnew countdown.
    // -----------------------------------------------------------------------
    assign issue_ok = !stall_int && !bus.ext_freeze && !bus.flush;

    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            slot_d[k] = '0;
        // Writes to r0 and non-writing instructions enter E as bubbles.
        if (issue_ok && bus.d_we && bus.d_wa != '0) begin
            slot_d[0].valid = 1'b1;
            slot_d[0].wa    = bus.d_wa;
            slot_d[0].tnew  = bus.d_tnew;
        end
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k].valid = slot_q[k-1].valid;
            slot_d[k].wa    = slot_q[k-1].wa;
            slot_d[k].tnew  = (slot_q[k-1].tnew == 2'd0) ? 2'd0 : slot_q[k-1].tnew - 2'd1;
        end
    end

    // NOTE: the slot array is small control state whose valid bits must be
    // clear out of reset, so it is reset explicitly rather than treated as
    // an uninitialised memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++)
                slot_q[k] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // slot samples the pre-edge value of its neighbour.
            for (int k = 0; k < DEPTH; k++)
                slot_q[k] <= slot_d[k];
        end
    end

    // A result that is still pending when it would leave W can never be
    // forwarded.
    a_tnew_range: assert property (@(posedge clk) disable iff (!reset)
        (issue_ok && bus.d_we && bus.d_wa != '0) |-> (int'(bus.d_tnew) <= DEPTH-1))
        else $error("fwd_scoreboard: d_tnew exceeds DEPTH-1");

`ifdef FWD_STAT_EN
    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
    logic [31:0] stall_cycles_q;
    logic [31:0] fwd_hits_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            fwd_hits_q     <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_q + {31'b0, stall_int};
            fwd_hits_q     <= fwd_hits_q + hit_cnt;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.fwd_hits     = fwd_hits_q;
`endif

endmodule
